// File: rtl/taxi_stats_pkg.sv
// Shared types and helpers for the multi-channel statistics accumulator.
package taxi_stats_pkg;

    // Widest record fields supported; instances slice down to their own widths.
    localparam int REC_ID_W  = 16;
    localparam int REC_VAL_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [REC_ID_W-1:0]  id;
        logic [REC_VAL_W-1:0] value;
        logic                 sat;
    } stat_rec_t;

    typedef struct packed {
        logic [REC_VAL_W-1:0] sum;
        logic                 overflow;
    } sat_sum_t;

    // Add inc to acc, clamping the result at 2^width-1 and flagging the clamp.
    function automatic sat_sum_t sat_add(input logic [REC_VAL_W-1:0] acc,
                                         input logic [REC_VAL_W-1:0] inc,
                                         input int unsigned width);
        logic [REC_VAL_W:0] full;
        logic [REC_VAL_W:0] limit;
        sat_sum_t           res;
        full  = {1'b0, acc} + {1'b0, inc};
        limit = ((REC_VAL_W+1)'(1) << width) - (REC_VAL_W+1)'(1);
        if (full > limit) begin
            res.sum      = limit[REC_VAL_W-1:0];
            res.overflow = 1'b1;
        end else begin
            res.sum      = full[REC_VAL_W-1:0];
            res.overflow = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/taxi_stats_accum_ch.sv
// One saturating statistics channel with a drain port that hands the count
// to the scan engine and restarts from the same-cycle increment.
module taxi_stats_accum_ch
    import taxi_stats_pkg::*;
#(
    parameter int INC_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc_i,
    input  logic             inc_valid_i,
    input  logic             drain_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             sat_o,
    output logic             hf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    sat_sum_t         add_res;
    logic             unused_add_bits;

    // Next count: a drain restarts from this cycle's increment so it is never lost.
    always_comb begin
        add_res = sat_add(REC_VAL_W'(acc_q), REC_VAL_W'(inc_i), ACC_W);
        acc_d   = acc_q;
        sat_d   = sat_q;
        if (drain_i) begin
            acc_d = inc_valid_i ? ACC_W'(inc_i) : '0;
            sat_d = 1'b0;
        end else if (inc_valid_i) begin
            acc_d = add_res.sum[ACC_W-1:0];
            sat_d = sat_q | add_res.overflow;
        end
    end

    // Count and sticky saturation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign unused_add_bits = ^add_res;
    assign acc_o = acc_q;
    assign sat_o = sat_q;
    assign hf_o  = acc_q[ACC_W-1];

endmodule

// File: rtl/taxi_stats_accum.sv
// Multi-channel statistics accumulator: CNT saturating counters drained as
// (id, value, sat) records on a single-register AXI4-Stream output.
module taxi_stats_accum
    import taxi_stats_pkg::*;
#(
    parameter int CNT           = 16,
    parameter int INC_W         = 8,
    parameter int ACC_W         = 16,
    parameter int ID_BASE       = 0,
    parameter int ID_W          = 8,
    parameter int DATA_W        = 32,
    parameter int UPDATE_PERIOD = 1024,
    parameter int ZERO_SKIP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT*INC_W-1:0] stat_inc_i,
    input  logic [CNT-1:0]       stat_valid_i,
    input  logic                 gate_i,
    input  logic                 update_i,
    output logic [DATA_W-1:0]    m_axis_stat_tdata_o,
    output logic [ID_W-1:0]      m_axis_stat_tid_o,
    output logic                 m_axis_stat_tuser_o,
    output logic                 m_axis_stat_tlast_o,
    output logic                 m_axis_stat_tvalid_o,
    input  logic                 m_axis_stat_tready_i,
    output logic                 busy_o
);

    localparam int PTR_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CNT - 1);

    logic [ACC_W-1:0]  acc_w [CNT];
    logic [CNT-1:0]    sat_w;
    logic [CNT-1:0]    hf_w;
    logic [CNT-1:0]    drain_w;

    scan_state_t       state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              busy_q;
    logic              flush_pend_q;
    logic              tvalid_q;
    logic [DATA_W-1:0] tdata_q;
    logic [ID_W-1:0]   tid_q;
    logic              tuser_q;

    logic              timer_wrap;
    logic              flush_req;
    logic              scan_start;
    logic              out_free;
    logic              scan_emit;
    logic [ACC_W-1:0]  acc_sel;
    logic              sat_sel;
    stat_rec_t         rec;
    logic              unused_rec_bits;

    for (genvar gi = 0; gi < CNT; gi++) begin : g_ch
        taxi_stats_accum_ch #(
            .INC_W (INC_W),
            .ACC_W (ACC_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (stat_inc_i[gi*INC_W +: INC_W]),
            .inc_valid_i (gate_i & stat_valid_i[gi]),
            .drain_i     (drain_w[gi]),
            .acc_o       (acc_w[gi]),
            .sat_o       (sat_w[gi]),
            .hf_o        (hf_w[gi])
        );
        assign drain_w[gi] = scan_emit && (ptr_q == PTR_W'(gi));
    end

    if (UPDATE_PERIOD > 0) begin : g_timer
        logic [TMR_W-1:0] timer_q;
        // Periodic flush timer, wrapping at UPDATE_PERIOD-1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                timer_q <= '0;
            end else if (timer_wrap) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
        end
        assign timer_wrap = (timer_q == TMR_W'(UPDATE_PERIOD - 1));
    end else begin : g_no_timer
        assign timer_wrap = 1'b0;
    end

    // Scan decisions and the record for the channel under the pointer.
    always_comb begin
        acc_sel    = acc_w[ptr_q];
        sat_sel    = sat_w[ptr_q];
        out_free   = !tvalid_q || m_axis_stat_tready_i;
        flush_req  = timer_wrap || update_i;
        scan_start = (state_q == IDLE) && (flush_pend_q || (|hf_w));
        scan_emit  = (state_q == SCAN) && out_free &&
                     ((acc_sel != '0) || (ZERO_SKIP == 0));
        rec.id     = REC_ID_W'(ID_BASE) + REC_ID_W'(ptr_q);
        rec.value  = REC_VAL_W'(acc_sel);
        rec.sat    = sat_sel;
    end

    // Scan FSM with the output record register; a request seen during a scan
    // stays pending so exactly one more scan follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tid_q        <= '0;
            tuser_q      <= 1'b0;
        end else begin
            flush_pend_q <= flush_req || (flush_pend_q && !scan_start);
            if (tvalid_q && m_axis_stat_tready_i) begin
                tvalid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_q <= SCAN;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (out_free) begin
                        if (scan_emit) begin
                            tvalid_q <= 1'b1;
                            tdata_q  <= DATA_W'(rec.value);
                            tid_q    <= rec.id[ID_W-1:0];
                            tuser_q  <= rec.sat;
                        end
                        if (ptr_q == PTR_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ptr_q <= ptr_q + PTR_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unused_rec_bits      = ^rec;
    assign m_axis_stat_tdata_o  = tdata_q;
    assign m_axis_stat_tid_o    = tid_q;
    assign m_axis_stat_tuser_o  = tuser_q;
    assign m_axis_stat_tlast_o  = 1'b1;
    assign m_axis_stat_tvalid_o = tvalid_q;
    assign busy_o               = busy_q;

endmodule

// File: tb/tb_taxi_stats_accum.sv
// Bench for taxi_stats_accum: three instances share one stimulus bus.
//   A: ACC_W=8,  timer off, zero-skip  (saturation, half-full, backpressure, reset, random)
//   B: ACC_W=16, period 16, zero-skip  (table-driven accumulation)
//   C: ACC_W=16, timer off, no skip    (every channel reported)
module tb_taxi_stats_accum;

    localparam int CNT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CNT*8-1:0] stat_inc;
    logic [CNT-1:0]  stat_valid;
    logic            gate, update, tready;

    logic [31:0] tdata_a, tdata_b, tdata_c;
    logic [7:0]  tid_a, tid_b, tid_c;
    logic        tuser_a, tuser_b, tuser_c;
    logic        tlast_a, tlast_b, tlast_c;
    logic        tvalid_a, tvalid_b, tvalid_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    taxi_stats_accum #(.CNT(CNT), .INC_W(8), .ACC_W(8), .ID_BASE(0), .ID_W(8), .DATA_W(32),
                       .UPDATE_PERIOD(0), .ZERO_SKIP(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .stat_inc_i(stat_inc), .stat_valid_i(stat_valid),
        .gate_i(gate), .update_i(update), .m_axis_stat_tdata_o(tdata_a),
        .m_axis_stat_tid_o(tid_a), .m_axis_stat_tuser_o(tuser_a), .m_axis_stat_tlast_o(tlast_a),
        .m_axis_stat_tvalid_o(tvalid_a), .m_axis_stat_tready_i(tready), .busy_o(busy_a));

    taxi_stats_accum #(.CNT(CNT), .INC_W(8), .ACC_W(16), .ID_BASE(0), .ID_W(8), .DATA_W(32),
                       .UPDATE_PERIOD(16), .ZERO_SKIP(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stat_inc_i(stat_inc), .stat_valid_i(stat_valid),
        .gate_i(gate), .update_i(update), .m_axis_stat_tdata_o(tdata_b),
        .m_axis_stat_tid_o(tid_b), .m_axis_stat_tuser_o(tuser_b), .m_axis_stat_tlast_o(tlast_b),
        .m_axis_stat_tvalid_o(tvalid_b), .m_axis_stat_tready_i(tready), .busy_o(busy_b));

    taxi_stats_accum #(.CNT(CNT), .INC_W(8), .ACC_W(16), .ID_BASE(0), .ID_W(8), .DATA_W(32),
                       .UPDATE_PERIOD(0), .ZERO_SKIP(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .stat_inc_i(stat_inc), .stat_valid_i(stat_valid),
        .gate_i(gate), .update_i(update), .m_axis_stat_tdata_o(tdata_c),
        .m_axis_stat_tid_o(tid_c), .m_axis_stat_tuser_o(tuser_c), .m_axis_stat_tlast_o(tlast_c),
        .m_axis_stat_tvalid_o(tvalid_c), .m_axis_stat_tready_i(tready), .busy_o(busy_c));

    typedef struct {
        int tid;
        int data;
        int user;
        int cyc;
    } rec_t;

    typedef struct {
        int ch;
        int inc;
        int n;
        int exp_sum;
    } vec_t;

    rec_t qa[$], qb[$], qc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Held-record bookkeeping for instance A.
    logic        pv_a, pr_a, pu_a;
    logic [31:0] pd_a;
    logic [7:0]  pi_a;

    always @(posedge clk) cyc <= cyc + 1;

    // Record collection and hold-stability checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_a = 1'b0;
            pr_a = 1'b1;
        end else begin
            if (pv_a && !pr_a) begin
                checks++;
                if (!(tvalid_a && tdata_a == pd_a && tid_a == pi_a && tuser_a == pu_a)) begin
                    failures++;
                    $display("FAIL axis_hold: got v=%0b d=%0d id=%0d u=%0b required v=1 d=%0d id=%0d u=%0b",
                             tvalid_a, tdata_a, tid_a, tuser_a, pd_a, pi_a, pu_a);
                end
            end
            if (tvalid_a && tready) qa.push_back('{int'(tid_a), int'(tdata_a), int'(tuser_a), cyc});
            if (tvalid_b && tready) qb.push_back('{int'(tid_b), int'(tdata_b), int'(tuser_b), cyc});
            if (tvalid_c && tready) qc.push_back('{int'(tid_c), int'(tdata_c), int'(tuser_c), cyc});
            pv_a = tvalid_a; pr_a = tready; pd_a = tdata_a; pi_a = tid_a; pu_a = tuser_a;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int ch, input int val);
        logic [7:0] v;
        v = 8'(val);
        stat_valid[ch] = 1'b1;
        stat_inc[ch*8 +: 8] = v;
    endtask

    task automatic clr_inc;
        stat_valid = '0;
        stat_inc   = '0;
    endtask

    task automatic qsum(input rec_t q[$], input int tid, output int s, output int n, output int nsat);
        s = 0; n = 0; nsat = 0;
        foreach (q[k]) begin
            if (q[k].tid == tid) begin
                s += q[k].data;
                n++;
                if (q[k].user != 0) nsat++;
            end
        end
    endtask

    // Force a scan on every instance and wait until all are quiet.
    task automatic flush(input bit clear_q);
        int n;
        tready = 1'b1;
        clr_inc();
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        tick();
        n = 0;
        while ((busy_a || busy_b || busy_c || tvalid_a || tvalid_b || tvalid_c) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL flush_timeout: got busy after %0d cycles required idle", n);
        end
        repeat (3) tick();
        if (clear_q) begin
            qa.delete(); qb.delete(); qc.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   s, n, ns, n3, cnt;
        int   tot[CNT];
        logic [31:0] hold_d;

        tbl[0] = '{2, 3, 5, 15};
        tbl[1] = '{0, 200, 3, 600};
        tbl[2] = '{3, 255, 4, 1020};
        tbl[3] = '{1, 1, 7, 7};

        gate = 1'b1; update = 1'b0; tready = 1'b1;
        clr_inc();
        repeat (3) tick();

        // Reset state on all instances.
        chk("rst_a_tvalid", tvalid_a, 0);
        chk("rst_a_tdata", tdata_a, 0);
        chk("rst_a_tid", tid_a, 0);
        chk("rst_a_tuser", tuser_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_b_all", {tvalid_b, tdata_b, tid_b, tuser_b, busy_b}, 0);
        chk("rst_c_all", {tvalid_c, tdata_c, tid_c, tuser_c, busy_c}, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven accumulation on B (timer-driven scans).
        for (int v = 0; v < 4; v++) begin
            flush(1'b1);
            for (int k = 0; k < tbl[v].n; k++) begin
                set_inc(tbl[v].ch, tbl[v].inc);
                tick();
                clr_inc();
            end
            repeat (40) tick();
            qsum(qb, tbl[v].ch, s, n, ns);
            chk($sformatf("tbl%0d_sum", v), s, tbl[v].exp_sum);
            chk($sformatf("tbl%0d_sat", v), ns, 0);
            chk($sformatf("tbl%0d_other_records", v), qb.size() - n, 0);
        end

        // Saturation on A: 200 then 100 into an 8-bit counter.
        flush(1'b1);
        set_inc(0, 200);
        tick();
        clr_inc();
        set_inc(0, 100);
        tick();
        clr_inc();
        repeat (12) tick();
        chk("sat_records", qa.size(), 1);
        if (qa.size() > 0) begin
            chk("sat_tid", qa[0].tid, 0);
            chk("sat_tdata", qa[0].data, 255);
            chk("sat_tuser", qa[0].user, 1);
        end
        qa.delete();
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (10) tick();
        chk("sat_followup_records", qa.size(), 0);

        // Half-full self-start on A with the timer disabled.
        flush(1'b1);
        set_inc(1, 128);
        tick();
        clr_inc();
        tick();
        chk("hf_start_busy", busy_a, 1);
        n = 1;
        while (busy_a && n < 50) begin
            tick();
            if (busy_a) n++;
        end
        chk("hf_busy_cycles", n, 4);
        repeat (2) tick();
        chk("hf_records", qa.size(), 1);
        if (qa.size() > 0) begin
            chk("hf_tid", qa[0].tid, 1);
            chk("hf_tdata", qa[0].data, 128);
            chk("hf_tuser", qa[0].user, 0);
        end

        // Backpressure on A while channel 3 keeps counting.
        flush(1'b1);
        tready = 1'b0;
        n3 = 0;
        set_inc(0, 5);
        set_inc(3, 1);
        update = 1'b1;
        n3++;
        tick();
        update = 1'b0;
        stat_valid[0] = 1'b0;
        stat_inc[7:0] = 8'd0;
        n3++;
        tick();
        n3++;
        tick();
        chk("bp_tvalid_start", tvalid_a, 1);
        hold_d = tdata_a;
        chk("bp_held_tdata", hold_d, 5);
        for (int k = 0; k < 10; k++) begin
            n3++;
            tick();
        end
        chk("bp_tvalid_after_hold", tvalid_a, 1);
        chk("bp_tdata_after_hold", tdata_a, hold_d);
        chk("bp_tid_after_hold", tid_a, 0);
        tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n3++;
            tick();
        end
        flush(1'b0);
        qsum(qa, 3, s, n, ns);
        chk("bp_ch3_total", s, n3);
        qsum(qa, 0, s, n, ns);
        chk("bp_ch0_total", s, 5);

        // No zero-skip on C: every channel reported in order, one per cycle.
        flush(1'b1);
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (10) tick();
        chk("noskip_records", qc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < qc.size()) begin
                chk($sformatf("noskip%0d_tid", k), qc[k].tid, k);
                chk($sformatf("noskip%0d_tdata", k), qc[k].data, 0);
                chk($sformatf("noskip%0d_cycle", k), qc[k].cyc - qc[0].cyc, k);
            end
        end

        // Reset in the middle of a held record on A.
        flush(1'b1);
        tready = 1'b0;
        set_inc(0, 5);
        update = 1'b1;
        tick();
        update = 1'b0;
        clr_inc();
        set_inc(2, 7);
        tick();
        clr_inc();
        tick();
        chk("mid_rst_pre_tvalid", tvalid_a, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", tvalid_a, 0);
        chk("mid_rst_tdata", tdata_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        tready = 1'b1;
        qa.delete();
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (10) tick();
        chk("post_rst_records", qa.size(), 0);

        // Randomized traffic on A against a conservation model:
        // every qualified increment appears in exactly one record.
        flush(1'b1);
        for (int c = 0; c < CNT; c++) tot[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            clr_inc();
            for (int c = 0; c < CNT; c++) begin
                if ($urandom_range(1, 0) == 1) set_inc(c, int'($urandom_range(7, 0)));
            end
            gate   = ($urandom_range(7, 0) != 0);
            tready = ($urandom_range(3, 0) != 0);
            update = ($urandom_range(49, 0) == 0);
            for (int c = 0; c < CNT; c++) begin
                if (gate && stat_valid[c]) tot[c] += int'(stat_inc[c*8 +: 8]);
            end
            tick();
        end
        gate = 1'b1;
        update = 1'b0;
        flush(1'b0);
        for (int c = 0; c < CNT; c++) begin
            qsum(qa, c, s, n, ns);
            if (ns > 0) chk($sformatf("rand_ch%0d_sat_bound", c), (s <= tot[c]), 1);
            else chk($sformatf("rand_ch%0d_sum", c), s, tot[c]);
        end
        cnt = 0;
        foreach (qa[k]) if (qa[k].data == 0 || qa[k].tid >= CNT) cnt++;
        chk("rand_bad_records", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
